// File: rtl/adder_operand_loader_if.sv
// Operand/result bus between the board-facing loader and the external 4-bit adder.
interface adder_operand_loader_if;
    localparam int unsigned DATA_W  = 4;
    localparam int unsigned STATE_W = 2;

    logic [DATA_W-1:0]  sw;
    logic               load_btn;
    logic [DATA_W-1:0]  sum_in;
    logic [DATA_W-1:0]  a;
    logic [DATA_W-1:0]  b;
    logic [DATA_W-1:0]  result;
    logic               carry;
    logic               done;
    logic [STATE_W-1:0] state;

    // Board/adder side: drives switches, button and the adder's sum.
    modport master (
        output sw, load_btn, sum_in,
        input  a, b, result, carry, done, state
    );

    // Loader side: consumes switches/button/sum, presents operands and result.
    modport slave (
        input  sw, load_btn, sum_in,
        output a, b, result, carry, done, state
    );
endinterface

// File: rtl/adder_operand_loader.sv
// Loads two 4-bit operands from switches on debounced button presses,
// captures the external adder's sum and reconstructs its carry-out.
module adder_operand_loader #(
    parameter int unsigned DB_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    adder_operand_loader_if.slave bus
);

    localparam int unsigned DATA_W = 4;
    localparam int unsigned CNT_W  = 20;
    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DB_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        HAVE_A = 2'b01,
        CALC   = 2'b10,
        SHOW   = 2'b11
    } state_t;

    logic [1:0]       sync_q;
    logic             btn_sync;
    logic             btn_db_q;
    logic [CNT_W-1:0] db_cnt_q;
    logic             press_q;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] a_q, a_d;
    logic [DATA_W-1:0] b_q, b_d;
    logic [DATA_W-1:0] result_q, result_d;
    logic              carry_q, carry_d;

    assign btn_sync = sync_q[1];

    // Two-flop synchronizer for the asynchronous button level.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], bus.load_btn};
        end
    end

    // Debounce: level must differ from btn_db for DB_CYCLES clocks in a row;
    // a rising debounced edge emits a one-cycle press on the following cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            btn_db_q <= 1'b0;
            db_cnt_q <= '0;
            press_q  <= 1'b0;
        end else begin
            press_q <= 1'b0;
            if (btn_sync == btn_db_q) begin
                db_cnt_q <= '0;
            end else if (db_cnt_q == DB_LAST) begin
                btn_db_q <= btn_sync;
                db_cnt_q <= '0;
                press_q  <= btn_sync;
            end else begin
                db_cnt_q <= db_cnt_q + CNT_W'(1);
            end
        end
    end

    // FSM and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
            carry_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            result_q <= result_d;
            carry_q  <= carry_d;
        end
    end

    // Next-state and register-update decode; CALC ignores presses.
    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        result_d = result_q;
        carry_d  = carry_q;
        case (state_q)
            IDLE: begin
                if (press_q) begin
                    a_d     = bus.sw;
                    state_d = HAVE_A;
                end
            end
            HAVE_A: begin
                if (press_q) begin
                    b_d     = bus.sw;
                    state_d = CALC;
                end
            end
            CALC: begin
                // A wrapped sum is smaller than either operand exactly when a+b >= 16.
                result_d = bus.sum_in;
                carry_d  = (bus.sum_in < a_q);
                state_d  = SHOW;
            end
            SHOW: begin
                if (press_q) begin
                    a_d     = bus.sw;
                    b_d     = '0;
                    state_d = HAVE_A;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output drive; done is a pure decode of the state register.
    assign bus.a      = a_q;
    assign bus.b      = b_q;
    assign bus.result = result_q;
    assign bus.carry  = carry_q;
    assign bus.done   = (state_q == SHOW);
    assign bus.state  = state_q;

endmodule

// File: doc/adder_operand_loader.md
ADDER_OPERAND_LOADER -- requirements
Module: adder_operand_loader

Interface
REQ-001 Parameter: DB_CYCLES, default 4, number of consecutive stable clocks required before the debounced button level changes; legal range 1..2^20-1.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  reset; synchronous, active-high.
REQ-004 sw  input  4  operand value from board switches; sampled only on an accepted press.
REQ-005 load_btn  input  1  raw, asynchronous, bouncing push-button level; high = pressed.
REQ-006 sum_in  input  4  4-bit sum returned by the downstream ripple-carry adder (carry-in tied 0, no carry-out).
REQ-007 a  output  4  operand A to adder, driven directly from a register.
REQ-008 b  output  4  operand B to adder, driven directly from a register.
REQ-009 result  output  4  registered sum captured from sum_in.
REQ-010 carry  output  1  registered unsigned carry-out of a+b, reconstructed locally.
REQ-011 done  output  1  high while a valid result is displayed.
REQ-012 state  output  2  current FSM state encoding.

Function
REQ-013 load_btn SHALL pass through a two-flop synchronizer before any other use.
REQ-014 A 20-bit debounce counter SHALL increment each cycle the synchronized level differs from btn_db and clear to 0 on any cycle they are equal.
REQ-015 When the counter reaches DB_CYCLES, btn_db SHALL take the synchronized level at that edge and the counter SHALL clear.
REQ-016 press SHALL be a single-cycle pulse, high exactly one cycle after each 0->1 transition of btn_db; releases generate no pulse.
REQ-017 FSM states and encodings: IDLE=00, HAVE_A=01, CALC=10, SHOW=11.
REQ-018 IDLE: on press, a <= sw, go to HAVE_A; otherwise hold.
REQ-019 HAVE_A: on press, b <= sw, go to CALC; otherwise hold.
REQ-020 CALC: unconditional single cycle; result <= sum_in, carry <= (sum_in < a), go to SHOW; press in this cycle SHALL be ignored.
REQ-021 SHOW: done = 1; on press, a <= sw, b <= 0, result and carry hold, go to HAVE_A.
REQ-022 done SHALL be a combinational decode of state==SHOW; high only in SHOW.
REQ-023 a and b SHALL change only per REQ-018/019/021, so sum_in is stable for the full cycle before capture in CALC.
REQ-024 Carry rule: unsigned 4-bit wrap; carry = 1 exactly when a+b >= 16 (e.g. 9+8 -> result 1, carry 1); 15+15 -> result 14, carry 1.
REQ-025 Latency: press cycle N -> state update at edge ending cycle N; B press -> result valid and done high two edges later.
REQ-026 Button held indefinitely SHALL produce exactly one press; bounce shorter than DB_CYCLES cycles SHALL produce no press.

Reset
REQ-027 On rst high at a rising edge: state=IDLE, a=0, b=0, result=0, carry=0, done=0, synchronizer flops=0, btn_db=0, counter=0, press=0.
REQ-028 rst SHALL override every transition, including mid-debounce and CALC; a press pending in the debouncer SHALL be discarded.
REQ-029 After rst deasserts, a button already held high SHALL produce one press once it is stable for DB_CYCLES cycles.

Verification
REQ-030 Reset: rst 2 cycles with load_btn=1, sw=F -> all outputs 0, state=00 during reset; after release exactly one press -> a=F, state=01.
REQ-031 Normal op: sw=3 press, sw=5 press (DB_CYCLES=4) -> state 01 then 10 then 11; result=8, carry=0, done=1; a=3, b=5 held.
REQ-032 Overflow: sw=9 press, sw=8 press -> result=1, carry=1; then sw=F, F -> result=E, carry=1.
REQ-033 Bounce: load_btn toggled every 2 cycles for 20 cycles, then low -> no press, state unchanged; then held high 6 cycles -> exactly one press.
REQ-034 Held button: load_btn high 100 cycles in IDLE -> a captured once, state=01 only, no advance to CALC.
REQ-035 Re-operation: in SHOW with result=8, sw=2 press -> a=2, b=0, done=0, state=01, result stays 8 until next CALC.
